cmsdk_ahb_to_ahb_apb_async_master: RTL and testbench
====================================================

# cmsdk_ahb_to_ahb_apb_async_master

Master-side controller of the AHB-Lite to AHB-Lite/APB4 asynchronous bridge, running in the HCLKM domain. It detects each new request semaphore toggle from the slave side and replays the captured transfer once, either as an AHB-Lite master transfer or as an APB4 transfer. It then returns the response (HRESP/PSLVERR) and toggles the return semaphore. Address, write-data and response data buffers live outside this block; it only drives their enables and selects.

## Interface
- Parameters: none.
- HCLKM  in  1  master-side clock.
- HRESETM  in  1  asynchronous reset, active-high.
- m_rx_sema_async  in  1  slave-to-master request semaphore, unsynchronised.
- m_tx_sema_q  in  1  master-to-slave semaphore register (external flop).
- m_tx_sema_en  out  1  semaphore register enable.
- m_tx_sema_nxt  out  1  semaphore next value, always ~m_tx_sema_q.
- m_ad_sel_apb  in  1  buffered HSELAPBS of the pending request.
- m_ad_write  in  1  buffered HWRITES of the pending request.
- m_mask  out  1  slave-to-master buffer mask; high when no request is pending.
- HTRANSM_bit1  out  1  AHB master HTRANS[1]; HTRANS[0] is tied 0 externally.
- HREADYM  in  1  AHB master HREADY.
- HRESPM  in  1  AHB master HRESP.
- PSELM  out  1  APB select.
- PENABLEM  out  1  APB enable.
- PREADYM  in  1  APB ready.
- PSLVERRM  in  1  APB slave error.
- m_hresp_en  out  1  response buffer load enable.
- m_hresp_nxt  out  1  response value to load.

## Operation
- Synchroniser: m_rx_sema_async passes through 2 flops, reset to 0, giving rx_sync.
- A request is pending when rx_sync != m_tx_sema_q. m_mask = (rx_sync == m_tx_sema_q).
- FSM states (3-bit): IDLE, AADDR, ADATA, PSETUP, PACCESS. Reset state is IDLE.
- IDLE:
  - If a request is pending and m_ad_sel_apb=0, go to AADDR.
  - If a request is pending and m_ad_sel_apb=1, go to PSETUP.
  - Otherwise stay in IDLE.
- AADDR: HTRANSM_bit1=1 (NONSEQ). When HREADYM=1, go to ADATA; otherwise hold.
- ADATA: HTRANSM_bit1=0. When HREADYM=1, complete with resp=HRESPM.
- In ADATA, a cycle with HRESPM=1 and HREADYM=0 (first cycle of an error) causes no action. No new transfer is issued because the FSM is already in its data phase.
- PSETUP: PSELM=1, PENABLEM=0, for exactly one cycle, then go to PACCESS.
- PACCESS: PSELM=1, PENABLEM=1. When PREADYM=1, complete with resp=PSLVERRM.
- Completion cycle:
  - m_tx_sema_en=1 and m_hresp_en=1.
  - m_hresp_nxt=resp.
  - Next state is IDLE.
- m_ad_write is only used externally to gate the HWDATA/PWDATA/PWRITE muxes. The FSM treats reads and writes identically.
- At most one transfer is outstanding. A new request is not accepted until the completion edge updates m_tx_sema_q.

## Timing
- Reset values: all outputs 0 except m_mask=1 and m_tx_sema_nxt=~m_tx_sema_q.
- Reset is asynchronous. Asserting it mid-transfer drops HTRANSM_bit1, PSELM and PENABLEM immediately and forces IDLE. The transfer is abandoned, because the slave side is reset in the same system reset.
- Latency from an m_rx_sema_async toggle to state exit from IDLE: 2 HCLKM edges of synchronisation plus 1 cycle in IDLE.
  - AHB minimum: AADDR 1 cycle, ADATA 1 cycle.
  - APB minimum: PSETUP 1 cycle, PACCESS 1 cycle.
- Completion outputs are combinational from state and HREADYM/PREADYM/HRESPM/PSLVERRM.
- A toggle arriving during a transfer is simply seen as still pending after IDLE is re-entered. The semaphore is protocol-limited to one toggle per round trip.

## Configuration
- CMSDK_AHB_TO_AHB_APB_ASYNC_APB_EN defined: behaviour as above.
- CMSDK_AHB_TO_AHB_APB_ASYNC_APB_EN undefined:
  - PSETUP and PACCESS are removed, and PSELM and PENABLEM are tied 0.
  - A pending request with m_ad_sel_apb=1 completes in its IDLE detection cycle with m_hresp_nxt=1 (error).

## Structure
- Package cmsdk_ahb_to_ahb_apb_async_pkg holds:
  - the state width and the encodings IDLE=000, AADDR=001, ADATA=010, PSETUP=011, PACCESS=100;
  - the semaphore-match helper function, shared with the slave side.
- Sub-module cmsdk_ahb_to_ahb_apb_async_sync: 2-flop synchroniser with asynchronous active-high reset. It is reused for the return path on the slave side.

## Test plan
- Reset: hold HRESETM=1 and toggle inputs -> all outputs 0, m_mask=1; 3 cycles after release with no toggle, still IDLE.
- AHB read with no wait states: toggle m_rx_sema_async, sel_apb=0, HREADYM=1, HRESPM=0 -> HTRANSM_bit1=1 in cycle 4; completion in cycle 5 with m_tx_sema_en=1, m_hresp_nxt=0; m_mask=1 from cycle 6.
- AHB error: in ADATA, drive HREADYM=0/HRESPM=1 then HREADYM=1/HRESPM=1 -> no completion in the first cycle, completion in the second with m_hresp_nxt=1; HTRANSM_bit1 stays 0 throughout.
- APB write with PREADYM low for 3 cycles and PSLVERRM=1 at ready -> PSELM=1 for 5 cycles, PENABLEM=1 for the last 4, m_hresp_nxt=1 on the final cycle.
- Macro undefined, APB request -> PSELM never asserted; completion in the detection cycle with m_hresp_nxt=1.
- HRESETM asserted during PACCESS -> PSELM and PENABLEM go 0 before the next edge; IDLE after release; no m_tx_sema_en pulse.

Source files
------------

// File: rtl/cmsdk_ahb_to_ahb_apb_async_pkg.sv
// Shared definitions for the AHB to AHB/APB asynchronous bridge.
// Holds the master FSM encoding and the semaphore-match helper that the
// slave side also uses.
package cmsdk_ahb_to_ahb_apb_async_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'b000,
    ST_AADDR   = 3'b001,
    ST_ADATA   = 3'b010,
    ST_PSETUP  = 3'b011,
    ST_PACCESS = 3'b100
  } state_e;

  // Semaphores match when no request is outstanding in that direction
  function automatic logic sema_match(input logic a, input logic b);
    return a == b;
  endfunction

endpackage

// File: rtl/cmsdk_ahb_to_ahb_apb_async_sync.sv
// Two-flop synchroniser for single-bit semaphores crossing clock domains.
// Also used on the return path in the slave-side controller.
module cmsdk_ahb_to_ahb_apb_async_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic q
);

  logic [1:0] ff_q;

  // Shift the asynchronous input through two flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff_q <= '0;
    else     ff_q <= {ff_q[0], d_async};
  end

  assign q = ff_q[1];

endmodule

// File: rtl/cmsdk_ahb_to_ahb_apb_async_master.sv
// Master-side controller of the AHB to AHB/APB asynchronous bridge.
// Replays each toggled request once on AHB-Lite or APB4 and returns the
// response plus a semaphore toggle. APB support is built only when
// CMSDK_AHB_TO_AHB_APB_ASYNC_APB_EN is defined; without it, APB requests
// complete immediately with an error response.
module cmsdk_ahb_to_ahb_apb_async_master
  import cmsdk_ahb_to_ahb_apb_async_pkg::*;
(
  input  logic HCLKM,
  input  logic HRESETM,
  input  logic m_rx_sema_async,
  input  logic m_tx_sema_q,
  output logic m_tx_sema_en,
  output logic m_tx_sema_nxt,
  input  logic m_ad_sel_apb,
  input  logic m_ad_write,
  output logic m_mask,
  output logic HTRANSM_bit1,
  input  logic HREADYM,
  input  logic HRESPM,
  output logic PSELM,
  output logic PENABLEM,
  input  logic PREADYM,
  input  logic PSLVERRM,
  output logic m_hresp_en,
  output logic m_hresp_nxt
);

  logic   rx_sync;
  logic   pending;
  logic   done;
  logic   resp;
  state_e state_q, state_d;
  logic   htrans_q;

  cmsdk_ahb_to_ahb_apb_async_sync u_rx_sync (
    .clk     (HCLKM),
    .rst     (HRESETM),
    .d_async (m_rx_sema_async),
    .q       (rx_sync)
  );

  assign pending = !sema_match(rx_sync, m_tx_sema_q);
  assign m_mask  = !pending;

  // Next-state and completion decode; reads and writes share one path
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    resp    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending) begin
          if (!m_ad_sel_apb) begin
            state_d = ST_AADDR;
          end else begin
`ifdef CMSDK_AHB_TO_AHB_APB_ASYNC_APB_EN
            state_d = ST_PSETUP;
`else
            // No APB port: answer at once with an error
            done    = 1'b1;
            resp    = 1'b1;
`endif
          end
        end
      end
      ST_AADDR: if (HREADYM) state_d = ST_ADATA;
      // First error cycle (HREADYM low) is just a wait state here
      ST_ADATA: if (HREADYM) begin
        done    = 1'b1;
        resp    = HRESPM;
        state_d = ST_IDLE;
      end
`ifdef CMSDK_AHB_TO_AHB_APB_ASYNC_APB_EN
      ST_PSETUP: state_d = ST_PACCESS;
      ST_PACCESS: if (PREADYM) begin
        done    = 1'b1;
        resp    = PSLVERRM;
        state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef CMSDK_AHB_TO_AHB_APB_ASYNC_APB_EN
  logic psel_q, penable_q;

  // State register with bus controls registered from the next state
  always_ff @(posedge HCLKM or posedge HRESETM) begin
    if (HRESETM) begin
      state_q   <= ST_IDLE;
      htrans_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      htrans_q  <= (state_d == ST_AADDR);
      psel_q    <= (state_d == ST_PSETUP) || (state_d == ST_PACCESS);
      penable_q <= (state_d == ST_PACCESS);
    end
  end

  assign PSELM    = psel_q;
  assign PENABLEM = penable_q;

  logic unused_inputs;
  assign unused_inputs = m_ad_write;
`else
  // State register with HTRANS registered from the next state
  always_ff @(posedge HCLKM or posedge HRESETM) begin
    if (HRESETM) begin
      state_q  <= ST_IDLE;
      htrans_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      htrans_q <= (state_d == ST_AADDR);
    end
  end

  assign PSELM    = 1'b0;
  assign PENABLEM = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{m_ad_write, PREADYM, PSLVERRM};
`endif

  assign HTRANSM_bit1  = htrans_q;
  assign m_tx_sema_en  = done;
  assign m_tx_sema_nxt = ~m_tx_sema_q;
  assign m_hresp_en    = done;
  assign m_hresp_nxt   = resp;

endmodule

// File: tb/tb_cmsdk_ahb_to_ahb_apb_async_master.sv
// Self-checking bench for the bridge master controller. Expected output
// timelines are computed per transfer from cycle counts (sync latency,
// wait states) rather than by stepping an FSM copy.
module tb_cmsdk_ahb_to_ahb_apb_async_master;

  logic HCLKM = 1'b0;
  logic HRESETM = 1'b1;
  logic m_rx_sema_async = 1'b0;
  logic m_tx_sema_q;
  logic m_tx_sema_en, m_tx_sema_nxt;
  logic m_ad_sel_apb = 1'b0, m_ad_write = 1'b0;
  logic m_mask, HTRANSM_bit1;
  logic HREADYM = 1'b1, HRESPM = 1'b0;
  logic PSELM, PENABLEM;
  logic PREADYM = 1'b1, PSLVERRM = 1'b0;
  logic m_hresp_en, m_hresp_nxt;

  int checks = 0;
  int failures = 0;
  logic tx_model = 1'b0;

  always #5 HCLKM = ~HCLKM;

  // External semaphore flop owned by the surrounding bridge
  always_ff @(posedge HCLKM or posedge HRESETM) begin
    if (HRESETM)           m_tx_sema_q <= 1'b0;
    else if (m_tx_sema_en) m_tx_sema_q <= m_tx_sema_nxt;
  end

  cmsdk_ahb_to_ahb_apb_async_master dut (
    .HCLKM(HCLKM), .HRESETM(HRESETM), .m_rx_sema_async(m_rx_sema_async),
    .m_tx_sema_q(m_tx_sema_q), .m_tx_sema_en(m_tx_sema_en), .m_tx_sema_nxt(m_tx_sema_nxt),
    .m_ad_sel_apb(m_ad_sel_apb), .m_ad_write(m_ad_write), .m_mask(m_mask),
    .HTRANSM_bit1(HTRANSM_bit1), .HREADYM(HREADYM), .HRESPM(HRESPM),
    .PSELM(PSELM), .PENABLEM(PENABLEM), .PREADYM(PREADYM), .PSLVERRM(PSLVERRM),
    .m_hresp_en(m_hresp_en), .m_hresp_nxt(m_hresp_nxt)
  );

  // Output vector: {htrans, psel, penable, sema_en, hresp_en, mask, sema_nxt}
  task automatic test_reset();
    logic [6:0] got;
    HRESETM = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge HCLKM);
      m_rx_sema_async = 1'($urandom); m_ad_sel_apb = 1'($urandom);
      HREADYM = 1'($urandom); HRESPM = 1'($urandom);
      PREADYM = 1'($urandom); PSLVERRM = 1'($urandom);
      #1;
      got = {HTRANSM_bit1, PSELM, PENABLEM, m_tx_sema_en, m_hresp_en, m_mask, m_tx_sema_nxt};
      checks++;
      if (got !== 7'b0000011) begin
        failures++;
        $display("FAIL reset_hold k=%0d got=%b exp=%b", k, got, 7'b0000011);
      end
    end
    @(negedge HCLKM);
    m_rx_sema_async = 1'b0;
    tx_model = 1'b0;
    HRESETM = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge HCLKM);
      HREADYM = 1'($urandom); HRESPM = 1'($urandom);
      #1;
      got = {HTRANSM_bit1, PSELM, PENABLEM, m_tx_sema_en, m_hresp_en, m_mask, m_tx_sema_nxt};
      checks++;
      if (got !== 7'b0000011) begin
        failures++;
        $display("FAIL reset_release k=%0d got=%b exp=%b", k, got, 7'b0000011);
      end
    end
  endtask

  // AHB transfer: aw address-phase waits, dw data-phase waits, err response
  task automatic test_ahb(input int aw, input int dw, input logic err);
    logic [6:0] got, exp;
    int c;
    c = 4 + aw + dw;
    for (int k = 0; k <= c + 1; k++) begin
      @(negedge HCLKM);
      if (k == 0) begin
        m_rx_sema_async = ~m_rx_sema_async;
        m_ad_write = 1'($urandom);
      end
      m_ad_sel_apb = 1'b0;
      PREADYM = 1'($urandom); PSLVERRM = 1'($urandom);
      if (k >= 3 && k <= 3 + aw) begin
        HREADYM = (k == 3 + aw); HRESPM = 1'($urandom);
      end else if (k >= 4 + aw && k <= c) begin
        HREADYM = (k == c);
        HRESPM = err && (k >= c - 1);
      end else begin
        HREADYM = 1'($urandom); HRESPM = 1'($urandom);
      end
      #1;
      exp = {(k >= 3 && k <= 3 + aw), 1'b0, 1'b0, (k == c), (k == c),
             !(k >= 2 && k <= c), ~tx_model};
      got = {HTRANSM_bit1, PSELM, PENABLEM, m_tx_sema_en, m_hresp_en, m_mask, m_tx_sema_nxt};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL ahb aw=%0d dw=%0d err=%0d k=%0d got=%b exp=%b", aw, dw, err, k, got, exp);
      end
      if (k == c) begin
        checks++;
        if (m_hresp_nxt !== err) begin
          failures++;
          $display("FAIL ahb_resp aw=%0d dw=%0d got=%b exp=%b", aw, dw, m_hresp_nxt, err);
        end
        tx_model = ~tx_model;
      end
    end
  endtask

`ifdef CMSDK_AHB_TO_AHB_APB_ASYNC_APB_EN
  // APB transfer: pw access-phase waits, slverr response
  task automatic test_apb(input int pw, input logic slverr);
    logic [6:0] got, exp;
    int c;
    c = 4 + pw;
    for (int k = 0; k <= c + 1; k++) begin
      @(negedge HCLKM);
      if (k == 0) begin
        m_rx_sema_async = ~m_rx_sema_async;
        m_ad_write = 1'($urandom);
      end
      m_ad_sel_apb = 1'b1;
      HREADYM = 1'($urandom); HRESPM = 1'($urandom);
      if (k >= 4 && k <= c) begin
        PREADYM = (k == c);
        PSLVERRM = (k == c) ? slverr : 1'($urandom);
      end else begin
        PREADYM = 1'($urandom); PSLVERRM = 1'($urandom);
      end
      #1;
      exp = {1'b0, (k >= 3 && k <= c), (k >= 4 && k <= c), (k == c), (k == c),
             !(k >= 2 && k <= c), ~tx_model};
      got = {HTRANSM_bit1, PSELM, PENABLEM, m_tx_sema_en, m_hresp_en, m_mask, m_tx_sema_nxt};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL apb pw=%0d k=%0d got=%b exp=%b", pw, k, got, exp);
      end
      if (k == c) begin
        checks++;
        if (m_hresp_nxt !== slverr) begin
          failures++;
          $display("FAIL apb_resp pw=%0d got=%b exp=%b", pw, m_hresp_nxt, slverr);
        end
        tx_model = ~tx_model;
      end
    end
  endtask
`else
  // APB request without APB support: error completion in detection cycle
  task automatic test_apb_disabled();
    logic [6:0] got, exp;
    for (int k = 0; k <= 3; k++) begin
      @(negedge HCLKM);
      if (k == 0) m_rx_sema_async = ~m_rx_sema_async;
      m_ad_sel_apb = 1'b1;
      HREADYM = 1'($urandom); HRESPM = 1'($urandom);
      PREADYM = 1'($urandom); PSLVERRM = 1'($urandom);
      #1;
      exp = {1'b0, 1'b0, 1'b0, (k == 2), (k == 2), (k != 2), ~tx_model};
      got = {HTRANSM_bit1, PSELM, PENABLEM, m_tx_sema_en, m_hresp_en, m_mask, m_tx_sema_nxt};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL apb_off k=%0d got=%b exp=%b", k, got, exp);
      end
      if (k == 2) begin
        checks++;
        if (m_hresp_nxt !== 1'b1) begin
          failures++;
          $display("FAIL apb_off_resp got=%b exp=1", m_hresp_nxt);
        end
        tx_model = ~tx_model;
      end
    end
  endtask
`endif

  // Reset asserted while a transfer is mid-flight (AHB address phase, or
  // APB access phase when built)
  task automatic test_reset_mid(input logic apb);
    logic [6:0] got;
    int stop;
    stop = apb ? 4 : 3;
    for (int k = 0; k <= stop; k++) begin
      @(negedge HCLKM);
      if (k == 0) m_rx_sema_async = ~m_rx_sema_async;
      m_ad_sel_apb = apb;
      HREADYM = 1'b0; PREADYM = 1'b0;
      #1;
    end
    checks++;
    if ((apb ? (PSELM & PENABLEM) : HTRANSM_bit1) !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_active apb=%0d got htrans=%b psel=%b pen=%b", apb, HTRANSM_bit1, PSELM, PENABLEM);
    end
    HRESETM = 1'b1;
    m_rx_sema_async = 1'b0;
    tx_model = 1'b0;
    #1;
    got = {HTRANSM_bit1, PSELM, PENABLEM, m_tx_sema_en, m_hresp_en, m_mask, m_tx_sema_nxt};
    checks++;
    if (got !== 7'b0000011) begin
      failures++;
      $display("FAIL reset_mid_async got=%b exp=%b", got, 7'b0000011);
    end
    @(negedge HCLKM);
    HRESETM = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge HCLKM);
      HREADYM = 1'b1; PREADYM = 1'b1;
      #1;
      got = {HTRANSM_bit1, PSELM, PENABLEM, m_tx_sema_en, m_hresp_en, m_mask, m_tx_sema_nxt};
      checks++;
      if (got !== 7'b0000011) begin
        failures++;
        $display("FAIL reset_mid_idle k=%0d got=%b exp=%b", k, got, 7'b0000011);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ahb(0, 0, 1'b0);
    test_ahb(0, 1, 1'b1);
    test_ahb(2, 3, 1'b1);
    for (int i = 0; i < 12; i++) begin
      int aw, dw;
      logic err;
      aw = $urandom_range(0, 3);
      dw = $urandom_range(0, 3);
      err = (dw > 0) ? 1'($urandom) : 1'b0;
      test_ahb(aw, dw, err);
    end
`ifdef CMSDK_AHB_TO_AHB_APB_ASYNC_APB_EN
    test_apb(3, 1'b1);
    test_apb(0, 1'b0);
    for (int i = 0; i < 6; i++) test_apb($urandom_range(0, 3), 1'($urandom));
    test_reset_mid(1'b1);
`else
    test_apb_disabled();
    test_ahb(1, 0, 1'b0);
    test_apb_disabled();
`endif
    test_reset_mid(1'b0);
    test_ahb(0, 0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
